// File: rtl/fetch_instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer of fetched instructions with
// their PC and fetch-time branch prediction, one-cycle flush, no empty bypass.

`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_instr_queue #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_aL,
    input  logic                    flush,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [`INSTR_WIDTH-1:0] enq_instr,
    input  logic [`ADDR_WIDTH-1:0]  enq_PC,
    input  logic                    enq_is_cond_branch,
    input  logic                    enq_br_prediction,
    input  logic [`ADDR_WIDTH-1:0]  enq_next_PC,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [`INSTR_WIDTH-1:0] deq_instr,
    output logic [`ADDR_WIDTH-1:0]  deq_PC,
    output logic                    deq_is_cond_branch,
    output logic                    deq_br_prediction,
    output logic [`ADDR_WIDTH-1:0]  deq_next_PC,
    output logic [PTR_WIDTH:0]      count
);

    localparam int ENTRY_W = `INSTR_WIDTH + 2 * `ADDR_WIDTH + 2;
    localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

    logic [PTR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [ENTRY_W-1:0]   enq_entry;
    logic [ENTRY_W-1:0]   head_entry;
    logic [PTR_WIDTH-1:0] wr_idx;
    logic [PTR_WIDTH-1:0] rd_idx;
    logic                 empty;
    logic                 full;
    logic                 enq_fire;
    logic                 deq_fire;

    // Status comes from the pointers alone so the handshakes never form a
    // combinational loop through enq_valid/deq_ready.
    always_comb begin
        wr_idx    = wr_ptr_q[PTR_WIDTH-1:0];
        rd_idx    = rd_ptr_q[PTR_WIDTH-1:0];
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_idx == rd_idx) && (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
        enq_ready = !full;
        deq_valid = !empty;
        enq_fire  = enq_valid && !full;
        deq_fire  = deq_ready && !empty;
        count     = wr_ptr_q - rd_ptr_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        enq_entry = {enq_instr, enq_PC, enq_is_cond_branch, enq_br_prediction, enq_next_PC};
    end

    // Storage has no reset; a write landing during reset is invisible because
    // wr_ptr stays at zero and the slot is overwritten by the next enqueue.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            mem_q[wr_idx] <= enq_entry;
        end
    end

    always_comb begin
        head_entry = mem_q[rd_idx];
        {deq_instr, deq_PC, deq_is_cond_branch, deq_br_prediction, deq_next_PC} = head_entry;
    end

endmodule
